seven_segment_scan_controller: RTL and testbench

Time-multiplexed scan controller for the integer seven-segment display path. It owns the one-hot digit-select rotation, prescales the system clock into per-digit time slots, and inserts an anti-ghosting blank interval at the start of every slot. It decodes each 4-bit digit to segments, with optional leading-zero suppression. New display values are double-buffered so that a frame never shows mixed old and new data.

---
 rtl/seven_segment_scan_controller.sv | 98 +++++++++
 tb/tb_seven_segment_scan_controller.sv | 134 +++++++++++++
 2 files changed

// File: rtl/seven_segment_scan_controller.sv
// seven_segment_scan_controller: multiplexed 7-seg scan with blanking, LZ suppression and double buffering
module seven_segment_scan_controller #(
  parameter int N_DIGITS     = 3,
  parameter int CLK_DIV      = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] digits_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  lz_suppress,
  output logic [N_DIGITS-1:0]   anode_sel,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic                  frame_done
);
  localparam int PW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int IW = N_DIGITS > 1 ? $clog2(N_DIGITS) : 1;
  localparam logic [15:0][6:0] SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };
  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;
  state_t                state_q, state_d;
  logic [PW-1:0]         presc_q, presc_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d, act_q, act_d;
  logic [N_DIGITS-1:0]   pdp_q, pdp_d, adp_q, adp_d;
  logic [N_DIGITS-1:0]   anode_d, zero_above;
  logic [6:0]            seg_d;
  logic                  dp_d, fd_d;
  logic                  slot_end, start, wrap, show, supp, dp_sel, z;
  logic [3:0]            nib;
  // Next-state, buffer swap and registered-output values for the state entered on this edge
  always_comb begin
    slot_end = presc_q == PW'(CLK_DIV - 1);
    start = state_q == IDLE && enable;
    wrap = state_q != IDLE && enable && slot_end && idx_q == IW'(N_DIGITS - 1);
    pend_d = load ? digits_in : pend_q;
    pdp_d = load ? dp_in : pdp_q;
    act_d = (start || wrap) ? pend_d : act_q;
    adp_d = (start || wrap) ? pdp_d : adp_q;
    presc_d = (!enable || state_q == IDLE || slot_end) ? '0 : presc_q + 1'b1;
    idx_d = (!enable || state_q == IDLE) ? '0 :
            slot_end ? (idx_q == IW'(N_DIGITS - 1) ? '0 : idx_q + 1'b1) : idx_q;
    state_d = !enable ? IDLE : presc_d < PW'(BLANK_CYCLES) ? BLANK : SHOW;
    z = 1'b1;
    zero_above = '0;
    for (int k = N_DIGITS - 1; k >= 0; k--) begin
      z = z && act_d[4*k +: 4] == 4'h0;
      zero_above[k] = z;
    end
    nib = 4'h0;
    dp_sel = 1'b0;
    supp = 1'b0;
    for (int k = 0; k < N_DIGITS; k++)
      if (idx_d == IW'(k)) begin
        nib = act_d[4*k +: 4];
        dp_sel = adp_d[k];
        supp = lz_suppress && k != 0 && zero_above[k];
      end
    show = state_d == SHOW;
    anode_d = show ? {{(N_DIGITS-1){1'b0}}, 1'b1} << idx_d : '0;
    seg_d = (show && !supp) ? SEG[nib] : 7'h00;
    dp_d = show && dp_sel;
    fd_d = wrap;
  end
  // Scan FSM, buffers and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      presc_q    <= '0;
      idx_q      <= '0;
      pend_q     <= '0;
      act_q      <= '0;
      pdp_q      <= '0;
      adp_q      <= '0;
      anode_sel  <= '0;
      segments   <= '0;
      dp         <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      presc_q    <= presc_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      act_q      <= act_d;
      pdp_q      <= pdp_d;
      adp_q      <= adp_d;
      anode_sel  <= anode_d;
      segments   <= seg_d;
      dp         <= dp_d;
      frame_done <= fd_d;
    end
  end
endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// tb_seven_segment_scan_controller: scoreboard bench with directed per-cycle expectations
module tb_seven_segment_scan_controller;
  typedef struct packed {
    logic [2:0] a;
    logic [6:0] s;
    logic       d;
    logic       f;
  } obs_t;
  logic        clk, reset_n, enable, load, lz_suppress;
  logic [11:0] digits_in;
  logic [2:0]  dp_in;
  logic [2:0]  anode_sel;
  logic [6:0]  segments;
  logic        dp, frame_done;
  obs_t        q[$];
  obs_t        e, got;
  int          checks = 0, errors = 0, cyc = 0;

  seven_segment_scan_controller #(.N_DIGITS(3), .CLK_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
    .digits_in(digits_in), .dp_in(dp_in), .lz_suppress(lz_suppress),
    .anode_sel(anode_sel), .segments(segments), .dp(dp), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected observation per clock whenever the scoreboard holds one
  always @(posedge clk) begin
    #1;
    cyc++;
    if (q.size() != 0) begin
      e = q.pop_front();
      got = {anode_sel, segments, dp, frame_done};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL scan cyc%0d: got anode=%b seg=%h dp=%b fd=%b, want anode=%b seg=%h dp=%b fd=%b",
                 cyc, got.a, got.s, got.d, got.f, e.a, e.s, e.d, e.f);
      end
    end
  end

  task automatic step(input obs_t x);
    q.push_back(x);
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic want(input int n, input logic [2:0] a, input logic [6:0] s, input logic d, input logic f);
    for (int i = 0; i < n; i++) step(obs_t'({a, s, d, f}));
  endtask

  task automatic frame(input logic [6:0] s0, input logic d0, input logic [6:0] s1, input logic d1,
                       input logic [6:0] s2, input logic d2, input logic f,
                       input logic ml, input logic [11:0] mv);
    want(1, 3'b000, 7'h00, 1'b0, f);
    want(1, 3'b000, 7'h00, 1'b0, 1'b0);
    want(6, 3'b001, s0, d0, 1'b0);
    want(2, 3'b000, 7'h00, 1'b0, 1'b0);
    want(3, 3'b010, s1, d1, 1'b0);
    if (ml) begin
      load = 1'b1;
      digits_in = mv;
    end
    want(3, 3'b010, s1, d1, 1'b0);
    want(2, 3'b000, 7'h00, 1'b0, 1'b0);
    want(6, 3'b100, s2, d2, 1'b0);
  endtask

  task automatic chk_now(input string name, input logic [11:0] want_v);
    checks++;
    if ({anode_sel, segments, dp, frame_done} !== want_v) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, {anode_sel, segments, dp, frame_done}, want_v);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; lz_suppress = 1'b0;
    digits_in = 12'h000; dp_in = 3'b000;
    #2 chk_now("reset_outputs", 12'h000);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_now("idle_outputs", 12'h000);
    // enable with 0x321 loaded on the same edge
    enable = 1'b1; load = 1'b1; digits_in = 12'h321;
    frame(7'h06, 0, 7'h5B, 0, 7'h4F, 0, 1'b0, 1'b0, 12'h000);
    // old values persist across a mid-frame load of 0x789
    frame(7'h06, 0, 7'h5B, 0, 7'h4F, 0, 1'b1, 1'b1, 12'h789);
    frame(7'h6F, 0, 7'h7F, 0, 7'h07, 0, 1'b1, 1'b0, 12'h000);
    // load on the wrap edge: 0x005, dp 010, suppression on
    load = 1'b1; digits_in = 12'h005; dp_in = 3'b010; lz_suppress = 1'b1;
    frame(7'h6D, 0, 7'h00, 1, 7'h00, 0, 1'b1, 1'b0, 12'h000);
    load = 1'b1; digits_in = 12'h000; dp_in = 3'b000;
    frame(7'h3F, 0, 7'h00, 0, 7'h00, 0, 1'b1, 1'b0, 12'h000);
    // enable dropped during digit1 SHOW
    load = 1'b1; digits_in = 12'h321; lz_suppress = 1'b0;
    want(1, 3'b000, 7'h00, 1'b0, 1'b1);
    want(1, 3'b000, 7'h00, 1'b0, 1'b0);
    want(6, 3'b001, 7'h06, 1'b0, 1'b0);
    want(2, 3'b000, 7'h00, 1'b0, 1'b0);
    want(3, 3'b010, 7'h5B, 1'b0, 1'b0);
    enable = 1'b0;
    want(3, 3'b000, 7'h00, 1'b0, 1'b0);
    enable = 1'b1;
    frame(7'h06, 0, 7'h5B, 0, 7'h4F, 0, 1'b0, 1'b0, 12'h000);
    // asynchronous reset mid digit0 SHOW
    want(1, 3'b000, 7'h00, 1'b0, 1'b1);
    want(1, 3'b000, 7'h00, 1'b0, 1'b0);
    want(3, 3'b001, 7'h06, 1'b0, 1'b0);
    #2 reset_n = 1'b0;
    #1 chk_now("async_reset", 12'h000);
    @(negedge clk);
    reset_n = 1'b1;
    frame(7'h3F, 0, 7'h3F, 0, 7'h3F, 0, 1'b0, 1'b0, 12'h000);
    want(1, 3'b000, 7'h00, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
